// File: rtl/shift_sequencer_if.sv
// Handshake and register-feedback bundle between a requester, shift_sequencer
// and the downstream right_shift_register.
interface shift_sequencer_if #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 5
);
   logic               start;
   logic [WIDTH-1:0]   data_in;
   logic [SHAMT_W-1:0] shamt;
   logic               mode_in;
   logic [WIDTH-1:0]   sr_out;
   logic               sr_enable;
   logic [WIDTH-1:0]   sr_in;
   logic               sr_mode;
   logic [WIDTH-1:0]   result;
   logic               busy;
   logic               done;

   modport slave (
      input  start, data_in, shamt, mode_in, sr_out,
      output sr_enable, sr_in, sr_mode, result, busy, done
   );

   modport master (
      output start, data_in, shamt, mode_in, sr_out,
      input  sr_enable, sr_in, sr_mode, result, busy, done
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: drives right_shift_register one bit per cycle,
// feeding its output back, and returns the final word with start/busy/done.
module shift_sequencer #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 5
) (
   input logic            clk,
   input logic            reset,
   shift_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

   localparam logic [SHAMT_W-1:0] MAX_N = SHAMT_W'(WIDTH);

   state_t             state;
   logic [SHAMT_W-1:0] count;
   logic [SHAMT_W-1:0] n;
   logic [WIDTH-1:0]   data_r;
   logic [WIDTH-1:0]   result_r;
   logic               mode_r;
   logic               busy_r;
   logic               done_r;
   logic               enable_r;
   logic               first_r;

   // Shifting by WIDTH or more is equivalent to shifting exactly WIDTH times.
   always_comb n = (bus.shamt > MAX_N) ? MAX_N : bus.shamt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         data_r   <= '0;
         mode_r   <= 1'b0;
         result_r <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         enable_r <= 1'b0;
         first_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  data_r <= bus.data_in;
                  mode_r <= bus.mode_in;
                  if (n == '0) begin
                     result_r <= bus.data_in;
                     done_r   <= 1'b1;
                     state    <= DONE;
                  end else begin
                     count    <= n;
                     busy_r   <= 1'b1;
                     enable_r <= 1'b1;
                     first_r  <= 1'b1;
                     state    <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               first_r <= 1'b0;
               count   <= count - 1'b1;
               if (count == SHAMT_W'(1)) begin
                  enable_r <= 1'b0;
                  state    <= CAPTURE;
               end
            end
            CAPTURE: begin
               result_r <= bus.sr_out;
               busy_r   <= 1'b0;
               done_r   <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_r   <= 1'b0;
               done_r   <= 1'b0;
               enable_r <= 1'b0;
               first_r  <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // The first shift seeds the register from the operand; later ones recirculate.
   always_comb begin
      bus.sr_in = '0;
      if (enable_r) bus.sr_in = first_r ? data_r : bus.sr_out;
   end

   assign bus.sr_enable = enable_r;
   assign bus.sr_mode   = enable_r & mode_r;
   assign bus.result    = result_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
endmodule
